counter_event_logger: RTL and testbench

Downstream stage of the 16-bit up/down counter host. It watches the host's `counter_value`, `counter_overflow` and `counter_underflow` outputs, plus a programmable match value. It timestamps each overflow, underflow or match event and buffers it in a small FIFO. The FIFO drains to a consumer over a valid/ready handshake, and a saturating counter records events lost when the FIFO is full.

---
 rtl/counter_event_logger_if.sv | 35 +++
 rtl/counter_event_logger.sv | 98 +++++++++
 tb/tb_counter_event_logger.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_event_logger_if.sv
// Signal bundle between the up/down counter host, the event logger and its consumer.
// The slave modport is the logger's view; the master modport is the host/consumer side.
interface counter_event_logger_if #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]  counter_value;
   logic              counter_overflow;
   logic              counter_underflow;
   logic [WIDTH-1:0]  match_value;
   logic              match_enable;
   logic              clear;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        out_type;
   logic [WIDTH-1:0]  out_timestamp;
   logic [WIDTH-1:0]  out_value;
   logic [DROP_W-1:0] drop_count;
   logic [LW-1:0]     fifo_level;

   modport master (
      output counter_value, counter_overflow, counter_underflow,
      output match_value, match_enable, clear, out_ready,
      input  out_valid, out_type, out_timestamp, out_value, drop_count, fifo_level
   );

   modport slave (
      input  counter_value, counter_overflow, counter_underflow,
      input  match_value, match_enable, clear, out_ready,
      output out_valid, out_type, out_timestamp, out_value, drop_count, fifo_level
   );
endinterface

// File: rtl/counter_event_logger.sv
// Timestamps overflow/underflow/match rising edges from the counter host into a small
// FIFO drained over valid/ready; events arriving while full and not draining are counted.
module counter_event_logger #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   counter_event_logger_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0]  r_ts;
   logic              r_ov_d;
   logic              r_un_d;
   logic              r_mt_d;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic [DROP_W-1:0] r_drop;

   logic [2:0]        r_mem_type [DEPTH];
   logic [WIDTH-1:0]  r_mem_ts   [DEPTH];
   logic [WIDTH-1:0]  r_mem_val  [DEPTH];

   logic              w_mt;
   logic [2:0]        w_ev;
   logic              w_push_req;
   logic              w_full;
   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;

   assign w_mt       = bus.match_enable && (bus.counter_value == bus.match_value);
   assign w_ev       = {w_mt && !r_mt_d,
                        bus.counter_underflow && !r_un_d,
                        bus.counter_overflow && !r_ov_d};
   assign w_push_req = |w_ev;
   assign w_full     = (r_level == LW'(DEPTH));
   assign w_valid    = (r_level != '0);
   assign w_pop      = w_valid && bus.out_ready;
   // A pop frees the head slot on the same edge, so a full FIFO still takes the push.
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts     <= '0;
         r_ov_d   <= 1'b0;
         r_un_d   <= 1'b0;
         r_mt_d   <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_drop   <= '0;
      end else begin
         // Edge history tracks the raw levels even through a clear, so held flags stay quiet.
         r_ov_d <= bus.counter_overflow;
         r_un_d <= bus.counter_underflow;
         r_mt_d <= w_mt;
         if (bus.clear) begin
            r_ts     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= '0;
         end else begin
            r_ts <= r_ts + WIDTH'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
               2'b10:   r_level <= r_level + LW'(1);
               2'b01:   r_level <= r_level - LW'(1);
               default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !bus.clear) begin
         r_mem_type[r_wr_ptr] <= w_ev;
         r_mem_ts[r_wr_ptr]   <= r_ts;
         r_mem_val[r_wr_ptr]  <= bus.counter_value;
      end
   end

   assign bus.out_valid     = w_valid;
   assign bus.out_type      = r_mem_type[r_rd_ptr];
   assign bus.out_timestamp = r_mem_ts[r_rd_ptr];
   assign bus.out_value     = r_mem_val[r_rd_ptr];
   assign bus.drop_count    = r_drop;
   assign bus.fifo_level    = r_level;
endmodule

// File: tb/tb_counter_event_logger.sv
// Bench for counter_event_logger: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a queue-based model.
module tb_counter_event_logger;
   localparam int WIDTH  = 16;
   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   counter_event_logger_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

   counter_event_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       typ;
      logic [WIDTH-1:0] ts;
      logic [WIDTH-1:0] val;
   } entry_t;

   entry_t            m_q[$];
   logic [WIDTH-1:0]  m_ts;
   int                m_drops;
   bit                m_prev_ov, m_prev_un, m_prev_mt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each edge pops if the consumer is ready, then appends any new event
   // if there is room; otherwise the loss is counted, capped at the drop counter's maximum.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_ts      = '0;
         m_drops   = 0;
         m_prev_ov = 0;
         m_prev_un = 0;
         m_prev_mt = 0;
      end else begin
         bit ov, un, mt;
         logic [2:0] ev;
         entry_t e;
         ov = bus.counter_overflow;
         un = bus.counter_underflow;
         mt = bus.match_enable && (bus.counter_value == bus.match_value);
         ev = {mt && !m_prev_mt, un && !m_prev_un, ov && !m_prev_ov};
         m_prev_ov = ov;
         m_prev_un = un;
         m_prev_mt = mt;
         if (bus.clear) begin
            m_q.delete();
            m_drops = 0;
            m_ts    = '0;
         end else begin
            if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
            if (ev != 3'b000) begin
               if (m_q.size() < DEPTH) begin
                  e.typ = ev;
                  e.ts  = m_ts;
                  e.val = bus.counter_value;
                  m_q.push_back(e);
               end else if (m_drops < (1 << DROP_W) - 1) begin
                  m_drops++;
               end
            end
            m_ts = m_ts + 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
         chk("level", 32'(bus.fifo_level), 32'(m_q.size()));
         chk("drop",  32'(bus.drop_count), 32'(m_drops));
         if (m_q.size() != 0) begin
            chk("head_type", 32'(bus.out_type), 32'(m_q[0].typ));
            chk("head_ts",   32'(bus.out_timestamp), 32'(m_q[0].ts));
            chk("head_val",  32'(bus.out_value), 32'(m_q[0].val));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulses(input int n, input logic [WIDTH-1:0] base);
      for (int i = 0; i < n; i++) begin
         bus.counter_value    = base + WIDTH'(i);
         bus.counter_overflow = 1'b1;
         step();
         bus.counter_overflow = 1'b0;
         step();
      end
   endtask

   initial begin
      logic [WIDTH-1:0] prev_ts;
      logic [WIDTH-1:0] last_val;
      n_tests = 0;
      n_fail  = 0;
      rst_n                 = 1'b0;
      bus.counter_value     = '0;
      bus.counter_overflow  = 1'b0;
      bus.counter_underflow = 1'b0;
      bus.match_value       = 16'hFFFF;
      bus.match_enable      = 1'b0;
      bus.clear             = 1'b0;
      bus.out_ready         = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_level", 32'(bus.fifo_level), 32'd0);
      chk("rst_drop",  32'(bus.drop_count), 32'd0);
      rst_n = 1'b1;

      // Single overflow sampled at ts = 5
      repeat (5) step();
      bus.counter_overflow = 1'b1;
      step();
      bus.counter_overflow = 1'b0;
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_type",  32'(bus.out_type), 32'b001);
      chk("t1_ts",    32'(bus.out_timestamp), 32'd5);
      chk("t1_val",   32'(bus.out_value), 32'd0);
      chk("t1_level", 32'(bus.fifo_level), 32'd1);

      // Held underflow yields one entry
      bus.counter_underflow = 1'b1;
      repeat (10) step();
      bus.counter_underflow = 1'b0;
      chk("t2_level", 32'(bus.fifo_level), 32'd2);
      bus.out_ready = 1'b1;
      step();
      chk("t2_type",  32'(bus.out_type), 32'b010);
      chk("t2_level1", 32'(bus.fifo_level), 32'd1);
      step();
      chk("t2_level0", 32'(bus.fifo_level), 32'd0);

      // Overflow and match on the same edge
      bus.out_ready     = 1'b0;
      bus.counter_value = 16'h1234;
      bus.match_value   = 16'h0000;
      bus.match_enable  = 1'b1;
      step();
      bus.counter_value    = 16'h0000;
      bus.counter_overflow = 1'b1;
      step();
      bus.counter_overflow = 1'b0;
      bus.counter_value    = 16'h1234;
      chk("t3_level", 32'(bus.fifo_level), 32'd1);
      chk("t3_type",  32'(bus.out_type), 32'b101);
      chk("t3_val",   32'(bus.out_value), 32'd0);
      bus.match_enable = 1'b0;
      bus.out_ready    = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // Fill and drop
      pulses(6, 16'h0100);
      chk("t4_level", 32'(bus.fifo_level), 32'd4);
      chk("t4_drop",  32'(bus.drop_count), 32'd2);

      // Full with simultaneous push and pop
      bus.out_ready        = 1'b1;
      bus.counter_value    = 16'hBEEF;
      bus.counter_overflow = 1'b1;
      step();
      bus.counter_overflow = 1'b0;
      chk("t5_level", 32'(bus.fifo_level), 32'd4);
      chk("t5_drop",  32'(bus.drop_count), 32'd2);
      prev_ts  = bus.out_timestamp;
      last_val = bus.out_value;
      for (int i = 1; i < 4; i++) begin
         step();
         chk("t4_ts_order", 32'(bus.out_timestamp > prev_ts), 32'd1);
         prev_ts  = bus.out_timestamp;
         last_val = bus.out_value;
      end
      chk("t5_last_val", 32'(last_val), 32'hBEEF);
      step();
      chk("t4_drained", 32'(bus.fifo_level), 32'd0);
      bus.out_ready = 1'b0;

      // Clear with a coincident event, held flag must not refire
      pulses(6, 16'h0200);
      bus.clear            = 1'b1;
      bus.counter_overflow = 1'b1;
      step();
      bus.clear = 1'b0;
      chk("t6_level", 32'(bus.fifo_level), 32'd0);
      chk("t6_drop",  32'(bus.drop_count), 32'd0);
      chk("t6_valid", 32'(bus.out_valid), 32'd0);
      bus.counter_underflow = 1'b1;
      step();
      bus.counter_underflow = 1'b0;
      chk("t6_ts0",   32'(bus.out_timestamp), 32'd0);
      chk("t6_type",  32'(bus.out_type), 32'b010);
      chk("t6_level1", 32'(bus.fifo_level), 32'd1);

      // Asynchronous reset mid-cycle
      bus.counter_overflow = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_async_level", 32'(bus.fifo_level), 32'd0);
      step();
      rst_n = 1'b1;

      // Drop counter saturation
      pulses(4 + 260, 16'h0300);
      chk("sat_drop",  32'(bus.drop_count), 32'd255);
      chk("sat_level", 32'(bus.fifo_level), 32'd4);
      pulses(2, 16'h0400);
      chk("sat_hold",  32'(bus.drop_count), 32'd255);

      // Randomized traffic
      bus.match_value = 16'h0003;
      for (int i = 0; i < 3000; i++) begin
         bus.counter_value     = WIDTH'($urandom_range(0, 7));
         bus.counter_overflow  = ($urandom_range(0, 3) == 0);
         bus.counter_underflow = ($urandom_range(0, 3) == 0);
         bus.match_enable      = ($urandom_range(0, 7) != 0);
         bus.out_ready         = ($urandom_range(0, 2) != 0);
         bus.clear             = ($urandom_range(0, 99) == 0);
         step();
      end
      bus.clear             = 1'b0;
      bus.counter_overflow  = 1'b0;
      bus.counter_underflow = 1'b0;
      bus.match_enable      = 1'b0;
      bus.out_ready         = 1'b1;
      repeat (DEPTH + 2) step();
      chk("final_empty", 32'(bus.fifo_level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
